// File: rtl/vrf_read_responder.sv
// vrf_read_responder
// Responder side of the VRF read-request channel. Each accepted request is
// issued to the lane SRAM bank in the same cycle; its tags ride a fixed-length
// pipeline that matches the SRAM read latency. Data and tags then land in a
// circular response queue. Requests are admitted only while the number of
// requests in flight plus queued is below DEPTH, so every SRAM result has a
// reserved queue slot and nothing is ever dropped under response backpressure.
module vrf_read_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    // request channel
    output logic                         io_req_ready,
    input  logic                         io_req_valid,
    input  logic [4:0]                   io_req_bits_vs,
    input  logic [1:0]                   io_req_bits_readSource,
    input  logic [8:0]                   io_req_bits_offset,
    input  logic [2:0]                   io_req_bits_instructionIndex,
    // SRAM bank
    output logic                         io_sram_ren,
    output logic [13:0]                  io_sram_addr,
    input  logic [DATA_WIDTH-1:0]        io_sram_rdata,
    // response channel
    input  logic                         io_resp_ready,
    output logic                         io_resp_valid,
    output logic [DATA_WIDTH-1:0]        io_resp_bits_data,
    output logic [1:0]                   io_resp_bits_readSource,
    output logic [2:0]                   io_resp_bits_instructionIndex,
    // debug / performance
    output logic [$clog2(DEPTH+1)-1:0]   io_outstanding
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Elaboration-time guard on the supported parameter range.
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("vrf_read_responder: READ_LATENCY must be in 1..4");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("vrf_read_responder: DEPTH must be at least 1");
    end

    // Advance a queue pointer, wrapping at DEPTH (which need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = '0;
        end else begin
            nxt = ptr + 1'b1;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Handshakes and credit counter
    // ------------------------------------------------------------------
    logic                 req_fire;
    logic                 resp_fire;
    logic [CNT_W-1:0]     outstanding_q;
    logic [CNT_W-1:0]     outstanding_d;

    // Admission depends only on the registered credit count, never on the
    // response side, so io_req_ready has no combinational input path.
    assign io_req_ready = (outstanding_q < DEPTH_C);
    assign req_fire     = io_req_valid & io_req_ready;
    assign resp_fire    = io_resp_valid & io_resp_ready;

    // SRAM access is issued in the accept cycle; the address is a pure concatenation.
    assign io_sram_ren  = req_fire;
    assign io_sram_addr = {io_req_bits_vs, io_req_bits_offset};

    // Credit count: +1 on accept, -1 on pop, unchanged when both or neither happen.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({req_fire, resp_fire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Credit count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign io_outstanding = outstanding_q;

    // ------------------------------------------------------------------
    // Stage p0..p(READ_LATENCY-1): tag pipeline shadowing the SRAM read.
    // Stage k holds the request issued k+1 cycles ago, so the last stage
    // lines up with io_sram_rdata for that request.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] vld_p_q;
    logic [1:0]              src_p_q [READ_LATENCY];
    logic [2:0]              idx_p_q [READ_LATENCY];

    // Valid bits of the tag pipeline; cleared on reset so late SRAM data is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p_q <= '0;
        end else begin
            vld_p_q[0] <= req_fire;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_p_q[k] <= vld_p_q[k-1];
            end
        end
    end

    // Tag payload of the pipeline; never stalls and needs no reset.
    always_ff @(posedge clock) begin
        src_p_q[0] <= io_req_bits_readSource;
        idx_p_q[0] <= io_req_bits_instructionIndex;
        for (int k = 1; k < READ_LATENCY; k++) begin
            src_p_q[k] <= src_p_q[k-1];
            idx_p_q[k] <= idx_p_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Response queue: circular buffer written from the last pipeline stage.
    // ------------------------------------------------------------------
    logic                  enq;
    logic                  q_full;
    logic                  q_empty;
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      wptr_d;
    logic [PTR_W-1:0]      rptr_q;
    logic [PTR_W-1:0]      rptr_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DATA_WIDTH-1:0] q_data_q [DEPTH];
    logic [1:0]            q_src_q  [DEPTH];
    logic [2:0]            q_idx_q  [DEPTH];

    assign enq     = vld_p_q[READ_LATENCY-1];
    assign q_full  = (count_q == DEPTH_C);
    assign q_empty = (count_q == '0);

    // Queue pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = next_ptr(wptr_q);
        end
        if (resp_fire) begin
            rptr_d = next_ptr(rptr_q);
        end
        case ({enq, resp_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Queue storage: capture SRAM data with its tags when the last stage is valid.
    always_ff @(posedge clock) begin
        if (enq) begin
            q_data_q[wptr_q] <= io_sram_rdata;
            q_src_q[wptr_q]  <= src_p_q[READ_LATENCY-1];
            q_idx_q[wptr_q]  <= idx_p_q[READ_LATENCY-1];
        end
    end

    // The head entry drives the response; it only moves on a pop, so the
    // response stays stable while the consumer is stalling.
    assign io_resp_valid                 = ~q_empty;
    assign io_resp_bits_data             = q_data_q[rptr_q];
    assign io_resp_bits_readSource       = q_src_q[rptr_q];
    assign io_resp_bits_instructionIndex = q_idx_q[rptr_q];

    // The credit rule reserves a slot for every in-flight read, so an
    // enqueue into a full queue means the credit accounting is broken.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(enq && q_full))
        else $error("vrf_read_responder: enqueue into full response queue");

    a_credit_bound: assert property (@(posedge clock) disable iff (reset)
        outstanding_q <= DEPTH_C)
        else $error("vrf_read_responder: outstanding count exceeds DEPTH");

endmodule

// File: tb/tb_vrf_read_responder.sv
// Testbench for vrf_read_responder: an SRAM model with fixed read latency
// plus an in-order scoreboard holding the expected response of every
// accepted request, looked up from the SRAM contents at request time.
`timescale 1ns/1ps
module tb_vrf_read_responder;

    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 4;

    typedef logic [DW+4:0] resp_t;   // {data, readSource, instructionIndex}

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_req_ready;
    logic          io_req_valid = 1'b0;
    logic [4:0]    io_req_bits_vs = '0;
    logic [1:0]    io_req_bits_readSource = '0;
    logic [8:0]    io_req_bits_offset = '0;
    logic [2:0]    io_req_bits_instructionIndex = '0;
    logic          io_sram_ren;
    logic [13:0]   io_sram_addr;
    logic [DW-1:0] io_sram_rdata;
    logic          io_resp_ready = 1'b0;
    logic          io_resp_valid;
    logic [DW-1:0] io_resp_bits_data;
    logic [1:0]    io_resp_bits_readSource;
    logic [2:0]    io_resp_bits_instructionIndex;
    logic [2:0]    io_outstanding;

    vrf_read_responder #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .DEPTH(DEPTH)) dut (
        .clock                         (clock),
        .reset                         (reset),
        .io_req_ready                  (io_req_ready),
        .io_req_valid                  (io_req_valid),
        .io_req_bits_vs                (io_req_bits_vs),
        .io_req_bits_readSource        (io_req_bits_readSource),
        .io_req_bits_offset            (io_req_bits_offset),
        .io_req_bits_instructionIndex  (io_req_bits_instructionIndex),
        .io_sram_ren                   (io_sram_ren),
        .io_sram_addr                  (io_sram_addr),
        .io_sram_rdata                 (io_sram_rdata),
        .io_resp_ready                 (io_resp_ready),
        .io_resp_valid                 (io_resp_valid),
        .io_resp_bits_data             (io_resp_bits_data),
        .io_resp_bits_readSource       (io_resp_bits_readSource),
        .io_resp_bits_instructionIndex (io_resp_bits_instructionIndex),
        .io_outstanding                (io_outstanding)
    );

    always #5 clock = ~clock;

    // SRAM model: data appears RL cycles after ren, garbage otherwise.
    logic [DW-1:0] mem [16384];
    logic [RL-1:0] sh_vld = '0;
    logic [13:0]   sh_addr [RL];

    always @(posedge clock) begin
        sh_vld[0]  <= io_sram_ren;
        sh_addr[0] <= io_sram_addr;
        for (int k = 1; k < RL; k++) begin
            sh_vld[k]  <= sh_vld[k-1];
            sh_addr[k] <= sh_addr[k-1];
        end
    end
    assign io_sram_rdata = sh_vld[RL-1] ? mem[sh_addr[RL-1]] : 32'hBAD0_0BAD;

    // Scoreboard state
    resp_t exp_q[$];
    resp_t exp_resp;
    resp_t obs_resp;
    logic  obs_pop;
    logic  obs_fire;
    logic  obs_valid;
    logic  pop_empty;
    int    n_total = 0;
    int    n_bad   = 0;
    int    cyc     = 0;

    function automatic resp_t cur_resp();
        return {io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex};
    endfunction

    task automatic rand_req_bits();
        io_req_bits_vs               = 5'($urandom);
        io_req_bits_offset           = 9'($urandom);
        io_req_bits_readSource       = 2'($urandom);
        io_req_bits_instructionIndex = 3'($urandom);
    endtask

    // One clock: record handshakes before the edge, update the model, then
    // advance to 1 ns after the edge where outputs are sampled.
    task automatic tick();
        logic rf;
        logic pf;
        #1;
        rf        = io_req_valid && io_req_ready;
        pf        = io_resp_valid && io_resp_ready;
        obs_valid = io_resp_valid;
        obs_resp  = cur_resp();
        obs_pop   = 1'b0;
        obs_fire  = 1'b0;
        pop_empty = 1'b0;
        if (!reset) begin
            if (pf) begin
                obs_pop = 1'b1;
                if (exp_q.size() == 0) pop_empty = 1'b1;
                else exp_resp = exp_q.pop_front();
            end
            if (rf) begin
                obs_fire = 1'b1;
                exp_q.push_back({mem[{io_req_bits_vs, io_req_bits_offset}],
                                 io_req_bits_readSource, io_req_bits_instructionIndex});
            end
        end
        @(posedge clock);
        #1;
        if (reset) exp_q.delete();
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_req_valid = 1'b0;
        io_resp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        n_total++;
        if (io_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_resp_valid: got %b want 0", io_resp_valid);
        end
        n_total++;
        if (io_outstanding !== 3'd0) begin
            n_bad++; $display("FAIL reset_outstanding: got %0d want 0", io_outstanding);
        end
        n_total++;
        if (io_sram_ren !== 1'b0) begin
            n_bad++; $display("FAIL reset_ren: got %b want 0", io_sram_ren);
        end
        n_total++;
        if (io_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_req_ready: got %b want 1", io_req_ready);
        end
    endtask

    task automatic test_single_read();
        mem[14'h0605] = 32'hDEADBEEF;
        io_req_valid = 1'b1;
        io_req_bits_vs = 5'd3;
        io_req_bits_offset = 9'h005;
        io_req_bits_readSource = 2'd2;
        io_req_bits_instructionIndex = 3'd5;
        #1;
        n_total++;
        if (io_sram_ren !== 1'b1 || io_sram_addr !== 14'h0605) begin
            n_bad++; $display("FAIL single_issue: ren=%b addr=%h want ren=1 addr=0605", io_sram_ren, io_sram_addr);
        end
        tick();                       // accept at T
        io_req_valid = 1'b0;
        #1;
        n_total++;
        if (io_sram_ren !== 1'b0) begin
            n_bad++; $display("FAIL single_no_ren: got %b want 0", io_sram_ren);
        end
        for (int t = 1; t <= 2; t++) begin
            n_total++;
            if (io_resp_valid !== 1'b0) begin
                n_bad++; $display("FAIL single_early_valid: T+%0d got %b want 0", t, io_resp_valid);
            end
            tick();
        end
        n_total++;                    // T+3
        if (io_resp_valid !== 1'b1 || cur_resp() !== {32'hDEADBEEF, 2'd2, 3'd5}) begin
            n_bad++; $display("FAIL single_resp: valid=%b resp=%h want valid=1 resp=%h",
                              io_resp_valid, cur_resp(), {32'hDEADBEEF, 2'd2, 3'd5});
        end
        io_resp_ready = 1'b1;
        tick();
        n_total++;
        if (!obs_pop || pop_empty || obs_resp !== exp_resp) begin
            n_bad++; $display("FAIL single_pop: pop=%b got %h want %h", obs_pop, obs_resp, exp_resp);
        end
        n_total++;
        if (io_resp_valid !== 1'b0 || io_outstanding !== 3'd0) begin
            n_bad++; $display("FAIL single_after: valid=%b outstanding=%0d want 0/0", io_resp_valid, io_outstanding);
        end
        io_resp_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int npop = 0;
        int first_pop = -1;
        int last_pop = -1;
        int guard = 0;
        io_resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_req_bits();
            io_req_bits_offset = 9'(i);
            io_req_valid = 1'b1;
            n_total++;
            if (io_req_ready !== 1'b1) begin
                n_bad++; $display("FAIL stream_ready: req %0d got %b want 1", i, io_req_ready);
            end
            tick();
            if (obs_pop) begin
                npop++; if (first_pop < 0) first_pop = cyc; last_pop = cyc;
                n_total++;
                if (pop_empty || obs_resp !== exp_resp) begin
                    n_bad++; $display("FAIL stream_data: got %h want %h", obs_resp, exp_resp);
                end
            end
            n_total++;
            if (io_outstanding > 3'd3 || io_outstanding !== 3'(exp_q.size())) begin
                n_bad++; $display("FAIL stream_outstanding: got %0d want %0d (max 3)", io_outstanding, exp_q.size());
            end
        end
        io_req_valid = 1'b0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
            if (obs_pop) begin
                npop++; if (first_pop < 0) first_pop = cyc; last_pop = cyc;
                n_total++;
                if (pop_empty || obs_resp !== exp_resp) begin
                    n_bad++; $display("FAIL stream_data: got %h want %h", obs_resp, exp_resp);
                end
            end
        end
        n_total++;
        if (npop != 16 || last_pop - first_pop != 15) begin
            n_bad++; $display("FAIL stream_count: pops=%0d span=%0d want 16/15", npop, last_pop - first_pop);
        end
        io_resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int    accepts = 0;
        logic  have_head = 1'b0;
        resp_t head = '0;
        io_resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_req_bits();
            io_req_valid = 1'b1;
            tick();
            if (obs_fire) accepts++;
            if (io_resp_valid) begin
                if (have_head) begin
                    n_total++;
                    if (cur_resp() !== head) begin
                        n_bad++; $display("FAIL bp_head_stable: got %h want %h", cur_resp(), head);
                    end
                end else begin
                    head = cur_resp();
                    have_head = 1'b1;
                end
            end
        end
        n_total++;
        if (accepts != 4 || io_req_ready !== 1'b0 || io_outstanding !== 3'd4) begin
            n_bad++; $display("FAIL bp_full: accepts=%0d ready=%b outstanding=%0d want 4/0/4",
                              accepts, io_req_ready, io_outstanding);
        end
        n_total++;
        if (io_resp_valid !== 1'b1 || cur_resp() !== exp_q[0]) begin
            n_bad++; $display("FAIL bp_head: valid=%b got %h want %h", io_resp_valid, cur_resp(), exp_q[0]);
        end
        io_req_valid = 1'b0;
        io_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (!obs_pop || pop_empty || obs_resp !== exp_resp) begin
                n_bad++; $display("FAIL bp_drain: pop=%b got %h want %h", obs_pop, obs_resp, exp_resp);
            end
            if (i == 0) begin
                n_total++;
                if (io_req_ready !== 1'b1) begin
                    n_bad++; $display("FAIL bp_ready_return: got %b want 1", io_req_ready);
                end
            end
        end
        n_total++;
        if (io_resp_valid !== 1'b0 || io_outstanding !== 3'd0) begin
            n_bad++; $display("FAIL bp_empty: valid=%b outstanding=%0d want 0/0", io_resp_valid, io_outstanding);
        end
        io_resp_ready = 1'b0;
    endtask

    task automatic test_simul();
        int guard = 0;
        io_resp_ready = 1'b0;
        while (io_req_ready && guard < 10) begin
            rand_req_bits();
            io_req_valid = 1'b1;
            tick();
            guard++;
        end
        io_req_valid = 1'b0;
        repeat (RL + 1) tick();
        n_total++;
        if (io_outstanding !== 3'd4 || io_resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL simul_fill: outstanding=%0d valid=%b want 4/1", io_outstanding, io_resp_valid);
        end
        rand_req_bits();
        io_req_valid = 1'b1;
        io_resp_ready = 1'b1;
        tick();                       // pop only, queue full
        n_total++;
        if (obs_fire || !obs_pop || io_outstanding !== 3'd3) begin
            n_bad++; $display("FAIL simul_pop_only: fire=%b pop=%b outstanding=%0d want 0/1/3",
                              obs_fire, obs_pop, io_outstanding);
        end
        n_total++;
        if (pop_empty || obs_resp !== exp_resp) begin
            n_bad++; $display("FAIL simul_data: got %h want %h", obs_resp, exp_resp);
        end
        rand_req_bits();
        tick();                       // accept and pop together
        n_total++;
        if (!obs_fire || !obs_pop || io_outstanding !== 3'd3) begin
            n_bad++; $display("FAIL simul_both: fire=%b pop=%b outstanding=%0d want 1/1/3",
                              obs_fire, obs_pop, io_outstanding);
        end
        n_total++;
        if (pop_empty || obs_resp !== exp_resp) begin
            n_bad++; $display("FAIL simul_data: got %h want %h", obs_resp, exp_resp);
        end
        for (int i = 0; i < 10; i++) begin
            rand_req_bits();
            io_req_valid  = 1'($urandom_range(0, 1));
            io_resp_ready = 1'($urandom_range(0, 1));
            tick();
            if (obs_pop) begin
                n_total++;
                if (pop_empty || obs_resp !== exp_resp) begin
                    n_bad++; $display("FAIL simul_mixed: got %h want %h", obs_resp, exp_resp);
                end
            end
            n_total++;
            if (io_outstanding !== 3'(exp_q.size())) begin
                n_bad++; $display("FAIL simul_count: got %0d want %0d", io_outstanding, exp_q.size());
            end
        end
        io_req_valid = 1'b0;
        io_resp_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
            if (obs_pop) begin
                n_total++;
                if (pop_empty || obs_resp !== exp_resp) begin
                    n_bad++; $display("FAIL simul_drain: got %h want %h", obs_resp, exp_resp);
                end
            end
        end
        n_total++;
        if (exp_q.size() != 0 || io_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL simul_drained: left=%0d valid=%b want 0/0", exp_q.size(), io_resp_valid);
        end
        io_resp_ready = 1'b0;
    endtask

    task automatic test_random();
        int accepted = 0;
        int popped = 0;
        int guard = 0;
        while ((accepted < 1000 || exp_q.size() > 0) && guard < 20000) begin
            rand_req_bits();
            io_req_valid  = (accepted < 1000) && ($urandom_range(0, 9) < 7);
            io_resp_ready = ($urandom_range(0, 9) < 6);
            n_total++;
            if (io_req_ready !== (exp_q.size() < DEPTH)) begin
                n_bad++; $display("FAIL rand_ready: got %b want %b", io_req_ready, exp_q.size() < DEPTH);
            end
            tick();
            guard++;
            if (obs_fire) accepted++;
            if (obs_pop) begin
                popped++;
                n_total++;
                if (pop_empty || obs_resp !== exp_resp) begin
                    n_bad++; $display("FAIL rand_data: got %h want %h", obs_resp, exp_resp);
                end
            end
            if (obs_valid && !obs_pop) begin
                n_total++;
                if (io_resp_valid !== 1'b1 || cur_resp() !== obs_resp) begin
                    n_bad++; $display("FAIL rand_hold: valid=%b got %h want %h", io_resp_valid, cur_resp(), obs_resp);
                end
            end
            n_total++;
            if (io_outstanding !== 3'(exp_q.size())) begin
                n_bad++; $display("FAIL rand_outstanding: got %0d want %0d", io_outstanding, exp_q.size());
            end
        end
        n_total++;
        if (accepted != 1000 || popped != 1000) begin
            n_bad++; $display("FAIL rand_totals: accepted=%0d popped=%0d want 1000/1000", accepted, popped);
        end
        io_req_valid = 1'b0;
        io_resp_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        logic done = 1'b0;
        io_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_req_bits();
            io_req_valid = 1'b1;
            tick();
        end
        io_req_valid = 1'b0;
        n_total++;
        if (io_outstanding !== 3'd4 || io_resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL mrst_setup: outstanding=%0d valid=%b want 4/1", io_outstanding, io_resp_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if (io_resp_valid !== 1'b0 || io_outstanding !== 3'd0) begin
            n_bad++; $display("FAIL mrst_clear: valid=%b outstanding=%0d want 0/0", io_resp_valid, io_outstanding);
        end
        io_resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (io_resp_valid !== 1'b0 || obs_pop) begin
                n_bad++; $display("FAIL mrst_stale: cycle %0d valid=%b want 0", i, io_resp_valid);
            end
        end
        rand_req_bits();
        io_req_valid = 1'b1;
        tick();
        io_req_valid = 1'b0;
        while (!done && guard < 10) begin
            tick();
            guard++;
            if (obs_pop) begin
                done = 1'b1;
                n_total++;
                if (pop_empty || obs_resp !== exp_resp) begin
                    n_bad++; $display("FAIL mrst_new: got %h want %h", obs_resp, exp_resp);
                end
            end
        end
        n_total++;
        if (!done || io_outstanding !== 3'd0) begin
            n_bad++; $display("FAIL mrst_complete: done=%b outstanding=%0d want 1/0", done, io_outstanding);
        end
        io_resp_ready = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) begin
            mem[a] = (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
        end
        test_reset();
        test_single_read();
        test_streaming();
        test_backpressure();
        test_simul();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
